// File: rtl/mem_bus_pkg.sv
// Shared types and default sizing for the mem_master bus sequencer.
package mem_bus_pkg;

    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_WAIT_CYCLES = 1;
    localparam int unsigned BEAT_W          = 2;
    localparam int unsigned TMR_W           = 4;

    typedef logic [BEAT_W-1:0] beat_cnt_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Countdown timing the idle cycles between the strobe and read-data capture.
module mem_wait_timer
    import mem_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt;

    // done tracks cnt == 0 one cycle ahead so it can be registered
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            done <= (load_val == '0);
        end else if (cnt != '0) begin
            cnt  <= cnt - TMR_W'(1);
            done <= (cnt == TMR_W'(1));
        end
    end

endmodule

// File: rtl/mem_master.sv
// Request/response to strobed-memory bus sequencer (SETUP, STROBE, WAIT, RESP).
// Optional read bursts are enabled by defining MEM_MASTER_BURST_EN.
module mem_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_in,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic              bus_cs,
    input  logic [DATA_W-1:0] bus_data_out
);

    localparam logic [TMR_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? TMR_W'(WAIT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    beat_cnt_t         beats_q, beats_d;
    beat_cnt_t         req_beats;

    logic              req_ready_d, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_d, bus_data_in_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic              bus_rd_d, bus_wr_d, bus_cs_d, active_d;
    logic              tmr_load, tmr_done;

    // extra beats after the first; writes never burst
`ifdef MEM_MASTER_BURST_EN
    assign req_beats = req_we ? '0 : beat_cnt_t'(req_len);
`else
    assign req_beats = '0;
    logic unused_len;
    assign unused_len = ^req_len;
`endif

    mem_wait_timer u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (WAIT_LOAD),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            beats_q     <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            bus_addr    <= '0;
            bus_data_in <= '0;
            bus_rd      <= 1'b0;
            bus_wr      <= 1'b0;
            bus_cs      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            beats_q     <= beats_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            bus_addr    <= bus_addr_d;
            bus_data_in <= bus_data_in_d;
            bus_rd      <= bus_rd_d;
            bus_wr      <= bus_wr_d;
            bus_cs      <= bus_cs_d;
        end
    end

    // next state, plus outputs decoded from the state being entered
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        beats_d    = beats_q;
        rsp_data_d = rsp_data;
        tmr_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = SETUP;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    beats_d = req_beats;
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
                if (WAIT_CYCLES == 0) begin
                    state_d    = RESP;
                    rsp_data_d = we_q ? '0 : bus_data_out;
                end else begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                end
            end
            WAIT: begin
                if (tmr_done) begin
                    state_d    = RESP;
                    rsp_data_d = we_q ? '0 : bus_data_out;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (beats_q != '0) begin
                        state_d = SETUP;
                        beats_d = beats_q - BEAT_W'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        active_d      = (state_d == SETUP) || (state_d == STROBE) || (state_d == WAIT);
        req_ready_d   = (state_d == IDLE);
        rsp_valid_d   = (state_d == RESP);
        bus_cs_d      = (state_d == STROBE);
        bus_rd_d      = active_d && !we_d;
        bus_wr_d      = active_d && we_d;
        bus_addr_d    = (state_d == SETUP) ? addr_d : bus_addr;
        bus_data_in_d = (state_d == SETUP) ? wdata_d : bus_data_in;
    end

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: timeline model plus directed vectors.
module tb_mem_master;

    localparam int WAITC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  req_len;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data, bus_addr, bus_data_in, bus_data_out;
    logic        bus_rd, bus_wr, bus_cs;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0;
    logic [15:0] rsp_data0, bus_addr0, bus_data_in0;
    logic        bus_rd0, bus_wr0, bus_cs0;
    logic [15:0] req_addr0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_master #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(WAITC)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .bus_addr(bus_addr), .bus_data_in(bus_data_in), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_cs(bus_cs), .bus_data_out(bus_data_out)
    );

    mem_master #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(1'b0), .req_addr(req_addr0), .req_wdata(16'h0000), .req_len(2'b00),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
        .bus_addr(bus_addr0), .bus_data_in(bus_data_in0), .bus_rd(bus_rd0),
        .bus_wr(bus_wr0), .bus_cs(bus_cs0), .bus_data_out(16'h5A00 ^ bus_addr0)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a * 16'h1010;
    endfunction

    // slave memory: unwritten words read as init_val(addr)
    logic [15:0] swr_val [256];
    bit          swr_en  [256];
    always @(posedge clk) begin
        if (bus_cs && bus_wr) begin
            swr_val[bus_addr[7:0]] <= bus_data_in;
            swr_en[bus_addr[7:0]]  <= 1'b1;
        end
    end
    assign bus_data_out = swr_en[bus_addr[7:0]] ? swr_val[bus_addr[7:0]] : init_val(bus_addr);

    // reference memory contents as seen by completed requests
    logic [15:0] mwr [int];
    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (mwr.exists(int'(a))) return mwr[int'(a)];
        return init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // model state: beat under way started (accepted) at cycle m_bs
    bit          chk_en = 0;
    bit          m_busy = 0;
    int          m_bs = 0;
    logic        m_we = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_exp = '0;
    int          cd;
    bit          e_act, e_rv;
    logic        prev_cs = 1'b0, prev_rv = 1'b0;
    int          seen_cs_cyc = -1, seen_rv_cyc = -1;
    logic [15:0] rsp_log [$];

    always @(negedge clk) begin
        if (chk_en) begin
            cd    = cyc - m_bs;
            e_act = m_busy && cd >= 1 && cd <= 2 + WAITC;
            e_rv  = m_busy && cd >= 3 + WAITC;
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("bus_cs", 32'(bus_cs), 32'(m_busy && cd == 2));
            chk("bus_rd", 32'(bus_rd), 32'(e_act && !m_we));
            chk("bus_wr", 32'(bus_wr), 32'(e_act && m_we));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            if (e_act) chk("bus_addr", 32'(bus_addr), 32'(m_addr));
            if (e_act && m_we) chk("bus_data_in", 32'(bus_data_in), 32'(m_wdata));
            if (e_rv) chk("rsp_data", 32'(rsp_data), 32'(m_exp));
            if (bus_cs && !prev_cs) seen_cs_cyc = cyc;
            if (rsp_valid && !prev_rv) seen_rv_cyc = cyc;
            prev_cs = bus_cs;
            prev_rv = rsp_valid;
        end
    end

    // called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle
    task automatic run_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] len, input int hold,
                           output int t0, output logic [15:0] first);
        int nb;
        int extra;
`ifdef MEM_MASTER_BURST_EN
        nb = we ? 1 : int'(len) + 1;
`else
        nb = 1;
`endif
        rsp_log.delete();
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_len = len;
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_busy = 1; m_bs = t0; m_we = we; m_addr = addr; m_wdata = wdata;
        m_exp = we ? 16'h0000 : model_rd(addr);
        for (int b = 0; b < nb; b++) begin
            extra = (b == 0) ? hold : 0;
            while (cyc < m_bs + 3 + WAITC + extra) begin
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
            rsp_log.push_back(rsp_data);
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            if (b < nb - 1) begin
                m_bs = cyc - 1; m_addr = m_addr + 16'd1; m_exp = model_rd(m_addr);
            end else begin
                m_busy = 0;
            end
        end
        if (we) mwr[int'(addr)] = wdata;
        first = rsp_log[0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        logic [15:0] got;

        rst = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_len = '0;
        rsp_ready = 0; req_valid0 = 0; req_addr0 = '0; rsp_ready0 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_data_in", 32'(bus_data_in), 32'd0);
        chk("rst_strobes", 32'({bus_cs, bus_rd, bus_wr}), 32'd0);
        rst = 1'b0;
        chk_en = 1;
        @(posedge clk); #1;

        // single read of a preloaded word, latency pinned by hand
        run_req(1'b0, 16'h0001, 16'h0000, 2'd0, 0, t0, got);
        chk("rd1_data", 32'(got), 32'h1010);
        chk("rd1_cs_cycle", 32'(seen_cs_cyc - t0), 32'd2);
        chk("rd1_rv_cycle", 32'(seen_rv_cyc - t0), 32'd4);

        // write then read back, back-to-back with no idle gap
        run_req(1'b1, 16'h0005, 16'h00AB, 2'd0, 0, t0, got);
        chk("wr_rsp_data", 32'(got), 32'h0);
        run_req(1'b0, 16'h0005, 16'h0000, 2'd0, 0, t0, got);
        chk("rdback_data", 32'(got), 32'h00AB);

        // response held off for five cycles
        run_req(1'b0, 16'h0007, 16'h0000, 2'd0, 5, t0, got);
        chk("hold_data", 32'(got), 32'h7070);
        chk("hold_rv_cycle", 32'(seen_rv_cyc - t0), 32'd4);

        // reset asserted while waiting for the read data
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0003; req_len = 2'd0;
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_busy = 1; m_bs = t0; m_we = 1'b0; m_addr = 16'h0003; m_exp = model_rd(16'h0003);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_busy = 0;
        chk("midrst_strobes", 32'({bus_cs, bus_rd, bus_wr}), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        run_req(1'b0, 16'h0002, 16'h0000, 2'd0, 0, t0, got);
        chk("postrst_data", 32'(got), 32'h2020);

        // length field: burst across the address wrap, or ignored
        run_req(1'b0, 16'hFFFE, 16'h0000, 2'd3, 0, t0, got);
`ifdef MEM_MASTER_BURST_EN
        chk("burst_count", 32'(rsp_log.size()), 32'd4);
        if (rsp_log.size() == 4) begin
            chk("burst_b0", 32'(rsp_log[0]), 32'hDFE0);
            chk("burst_b1", 32'(rsp_log[1]), 32'hEFF0);
            chk("burst_b2", 32'(rsp_log[2]), 32'h0000);
            chk("burst_b3", 32'(rsp_log[3]), 32'h1010);
        end
`else
        chk("nolen_data", 32'(got), 32'hDFE0);
`endif
        run_req(1'b1, 16'h0009, 16'h1234, 2'd3, 0, t0, got);
        run_req(1'b0, 16'h0009, 16'h0000, 2'd0, 0, t0, got);
        chk("wrlen_rdback", 32'(got), 32'h1234);
        chk_en = 0;

        // zero wait cycles: response two cycles after the strobe setup
        req_valid0 = 1'b1; req_addr0 = 16'h0033; rsp_ready0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        chk("w0_setup_cs", 32'(bus_cs0), 32'd0);
        chk("w0_setup_rd", 32'(bus_rd0), 32'd1);
        chk("w0_setup_ready", 32'(req_ready0), 32'd0);
        chk("w0_setup_din", 32'(bus_data_in0), 32'd0);
        @(posedge clk); #1;
        chk("w0_strobe_cs", 32'(bus_cs0), 32'd1);
        chk("w0_strobe_rv", 32'(rsp_valid0), 32'd0);
        @(posedge clk); #1;
        chk("w0_resp_rv", 32'(rsp_valid0), 32'd1);
        chk("w0_resp_data", 32'(rsp_data0), 32'h5A33);
        chk("w0_resp_strobes", 32'({bus_cs0, bus_rd0, bus_wr0}), 32'd0);
        @(posedge clk); #1;
        rsp_ready0 = 1'b0;
        chk("w0_idle_rv", 32'(rsp_valid0), 32'd0);
        chk("w0_idle_ready", 32'(req_ready0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
